duck_game_ctrl: RTL and testbench

Game-flow controller for the duck hunt design. It drives the 3-bit `state` bus and the `new_round` strobe that the duck sprite block consumes. It takes back that block's `flew_away`, `duck_ded_done` and `duck_x/duck_y` outputs, together with the crosshair position and trigger. From these it decides hits, shots, ducks per round, score, and game over.

---
 rtl/duck_pkg.sv | 20 ++
 rtl/duck_game_ctrl_if.sv | 36 +++
 rtl/duck_hit_test.sv | 25 ++
 rtl/duck_game_ctrl.sv | 159 +++++++++++++++
 tb/tb_duck_game_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/duck_pkg.sv
// Shared types and default sizing for the duck hunt game-flow logic.
package duck_pkg;

  // Encodings are decoded directly by the duck sprite block; do not reorder.
  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StNewDuck  = 3'b001,
    StFlying   = 3'b010,
    StFlew     = 3'b011,
    StShot     = 3'b100,
    StRoundEnd = 3'b101,
    StGameOver = 3'b110
  } game_state_t;

  localparam int unsigned DefDuckSize     = 64;
  localparam int unsigned DefShotsPerDuck = 3;
  localparam int unsigned DefDucksPerRound = 10;
  localparam int unsigned DefPassHits     = 6;

endpackage

// File: rtl/duck_game_ctrl_if.sv
// Signal bundle between the game-flow controller and its environment
// (sprite block, crosshair, trigger, frame clock).
interface duck_game_ctrl_if;
  import duck_pkg::*;

  logic        frame_clk;
  logic        start;
  logic        trigger;
  logic [9:0]  aim_x;
  logic [9:0]  aim_y;
  logic [9:0]  duck_x;
  logic [9:0]  duck_y;
  logic        flew_away;
  logic        duck_ded_done;

  game_state_t state;
  logic        new_round;
  logic [1:0]  shots_left;
  logic [3:0]  hits;
  logic [3:0]  duck_num;
  logic [7:0]  round_num;
  logic [15:0] score;

  // Environment side: drives game inputs, observes controller status.
  modport master (
    output frame_clk, start, trigger, aim_x, aim_y, duck_x, duck_y, flew_away, duck_ded_done,
    input  state, new_round, shots_left, hits, duck_num, round_num, score
  );

  // Controller side.
  modport slave (
    input  frame_clk, start, trigger, aim_x, aim_y, duck_x, duck_y, flew_away, duck_ded_done,
    output state, new_round, shots_left, hits, duck_num, round_num, score
  );

endinterface

// File: rtl/duck_hit_test.sv
// Combinational hit test: aim inside the square duck box, low bound inclusive,
// high bound exclusive. Upper bounds are formed at 11 bits so a duck near the
// right/bottom edge does not wrap.
module duck_hit_test
  import duck_pkg::*;
#(
  parameter int unsigned DuckSize = DefDuckSize
) (
  input  logic [9:0] aim_x_i,
  input  logic [9:0] aim_y_i,
  input  logic [9:0] duck_x_i,
  input  logic [9:0] duck_y_i,
  output logic       hit_o
);

  logic [10:0] x_hi;
  logic [10:0] y_hi;

  assign x_hi = {1'b0, duck_x_i} + 11'(DuckSize);
  assign y_hi = {1'b0, duck_y_i} + 11'(DuckSize);

  assign hit_o = (aim_x_i >= duck_x_i) && ({1'b0, aim_x_i} < x_hi) &&
                 (aim_y_i >= duck_y_i) && ({1'b0, aim_y_i} < y_hi);

endmodule

// File: rtl/duck_game_ctrl.sv
// Game-flow controller: sequences ducks and rounds, counts shots, hits and
// score, and tells the sprite block which phase the game is in.
module duck_game_ctrl
  import duck_pkg::*;
#(
  parameter int unsigned SHOTS_PER_DUCK  = DefShotsPerDuck,
  parameter int unsigned DUCKS_PER_ROUND = DefDucksPerRound,
  parameter int unsigned PASS_HITS       = DefPassHits,
  parameter int unsigned HIT_POINTS      = 500,
  parameter int unsigned AWAY_FRAMES     = 60,
  parameter int unsigned DUCK_SIZE       = DefDuckSize
) (
  input logic             Clk,
  input logic             Reset_n,
  duck_game_ctrl_if.slave game_io
);

  localparam int unsigned AwayW = (AWAY_FRAMES > 1) ? $clog2(AWAY_FRAMES) : 1;

  logic [2:0]       frame_sync_q;
  logic [2:0]       trig_sync_q;
  logic             frame_edge;
  logic             trig_edge;
  logic             hit;
  logic             more_ducks;
  logic [16:0]      score_sum;
  logic [15:0]      score_inc;

  game_state_t      state_q;
  logic             new_round_q;
  logic [1:0]       shots_left_q;
  logic [3:0]       hits_q;
  logic [3:0]       duck_num_q;
  logic [7:0]       round_num_q;
  logic [15:0]      score_q;
  logic [AwayW-1:0] away_cnt_q;

  // Two-flop synchronizers plus a third flop for rising-edge detection.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_sync_q <= '0;
      trig_sync_q  <= '0;
    end else begin
      frame_sync_q <= {frame_sync_q[1:0], game_io.frame_clk};
      trig_sync_q  <= {trig_sync_q[1:0], game_io.trigger};
    end
  end

  assign frame_edge = frame_sync_q[1] & ~frame_sync_q[2];
  assign trig_edge  = trig_sync_q[1] & ~trig_sync_q[2];

  duck_hit_test #(
    .DuckSize (DUCK_SIZE)
  ) u_hit_test (
    .aim_x_i  (game_io.aim_x),
    .aim_y_i  (game_io.aim_y),
    .duck_x_i (game_io.duck_x),
    .duck_y_i (game_io.duck_y),
    .hit_o    (hit)
  );

  assign more_ducks = duck_num_q < 4'(DUCKS_PER_ROUND);
  assign score_sum  = {1'b0, score_q} + 17'(HIT_POINTS);
  assign score_inc  = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Game FSM and counters; every output is a register updated here.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      new_round_q  <= 1'b0;
      shots_left_q <= '0;
      hits_q       <= '0;
      duck_num_q   <= '0;
      round_num_q  <= '0;
      score_q      <= '0;
      away_cnt_q   <= '0;
    end else begin
      new_round_q <= 1'b0;
      case (state_q)
        StIdle, StGameOver: begin
          if (game_io.start) begin
            state_q      <= StNewDuck;
            new_round_q  <= 1'b1;
            round_num_q  <= 8'd1;
            score_q      <= '0;
            hits_q       <= '0;
            // Duck count and shots are loaded on entry to NEW_DUCK.
            duck_num_q   <= 4'd1;
            shots_left_q <= 2'(SHOTS_PER_DUCK);
          end
        end
        StNewDuck: begin
          if (frame_edge) state_q <= StFlying;
        end
        StFlying: begin
          if (game_io.flew_away) begin
            state_q    <= StFlew;
            away_cnt_q <= '0;
          end else if (trig_edge && (shots_left_q != '0)) begin
            shots_left_q <= shots_left_q - 2'd1;
            if (hit) begin
              hits_q  <= hits_q + 4'd1;
              score_q <= score_inc;
              state_q <= StShot;
            end
          end
        end
        StShot: begin
          if (game_io.duck_ded_done) begin
            if (more_ducks) begin
              state_q      <= StNewDuck;
              duck_num_q   <= duck_num_q + 4'd1;
              shots_left_q <= 2'(SHOTS_PER_DUCK);
            end else begin
              state_q <= StRoundEnd;
            end
          end
        end
        StFlew: begin
          if (frame_edge) begin
            if (away_cnt_q == AwayW'(AWAY_FRAMES - 1)) begin
              if (more_ducks) begin
                state_q      <= StNewDuck;
                duck_num_q   <= duck_num_q + 4'd1;
                shots_left_q <= 2'(SHOTS_PER_DUCK);
              end else begin
                state_q <= StRoundEnd;
              end
            end else begin
              away_cnt_q <= away_cnt_q + 1'b1;
            end
          end
        end
        StRoundEnd: begin
          if (hits_q >= 4'(PASS_HITS)) begin
            state_q      <= StNewDuck;
            new_round_q  <= 1'b1;
            round_num_q  <= (round_num_q == 8'hFF) ? round_num_q : round_num_q + 8'd1;
            hits_q       <= '0;
            duck_num_q   <= 4'd1;
            shots_left_q <= 2'(SHOTS_PER_DUCK);
          end else begin
            state_q <= StGameOver;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign game_io.state      = state_q;
  assign game_io.new_round  = new_round_q;
  assign game_io.shots_left = shots_left_q;
  assign game_io.hits       = hits_q;
  assign game_io.duck_num   = duck_num_q;
  assign game_io.round_num  = round_num_q;
  assign game_io.score      = score_q;

endmodule

// File: tb/tb_duck_game_ctrl.sv
// Scoreboard bench for duck_game_ctrl: stimulus tasks push the expected
// output snapshot for every output change; a monitor pops on each change.
module tb_duck_game_ctrl;
  import duck_pkg::*;

  typedef struct packed {
    logic [2:0]  st;
    logic        nr;
    logic [1:0]  sh;
    logic [3:0]  hi;
    logic [3:0]  dn;
    logic [7:0]  rn;
    logic [15:0] sc;
  } snap_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  duck_game_ctrl_if bus ();

  duck_game_ctrl dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .game_io (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    bus.frame_clk = 1'b0;
    forever #100 bus.frame_clk = ~bus.frame_clk;
  end

  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_shots, m_hits, m_dn, m_rn, m_score;

  function automatic snap_t cur_snap();
    snap_t s;
    s.st = bus.state;
    s.nr = bus.new_round;
    s.sh = bus.shots_left;
    s.hi = bus.hits;
    s.dn = bus.duck_num;
    s.rn = bus.round_num;
    s.sc = bus.score;
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d nr=%0d shots=%0d hits=%0d duck=%0d round=%0d score=%0d",
                     s.st, s.nr, s.sh, s.hi, s.dn, s.rn, s.sc);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    snap_t prev, cur, e;
    prev = cur_snap();
    forever begin
      @(negedge Clk);
      cur = cur_snap();
      if (cur !== prev) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got %s", fmt(cur));
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL snapshot: got %s, expected %s", fmt(cur), fmt(e));
          end
        end
        prev = cur;
      end
    end
  endtask

  task automatic push(game_state_t st, logic nr);
    snap_t s;
    s.st = st;
    s.nr = nr;
    s.sh = 2'(m_shots);
    s.hi = 4'(m_hits);
    s.dn = 4'(m_dn);
    s.rn = 8'(m_rn);
    s.sc = 16'(m_score);
    exp_q.push_back(s);
  endtask

  task automatic wait_state(game_state_t st, int budget, string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge Clk); #1;
      if (bus.state == st) break;
    end
    if (i == budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s: state %0d, required %0d", name, bus.state, st);
    end
  endtask

  task automatic pull_trigger();
    bus.trigger = 1'b1;
    repeat (4) @(posedge Clk);
    #1 bus.trigger = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  // Next-duck decision as seen from the outputs.
  task automatic decide();
    if (m_dn < 10) begin
      m_dn++;
      m_shots = 3;
      push(StNewDuck, 1'b0);
    end else begin
      push(StRoundEnd, 1'b0);
      if (m_hits >= 6) begin
        m_rn++;
        m_hits  = 0;
        m_dn    = 1;
        m_shots = 3;
        push(StNewDuck, 1'b1);
        push(StNewDuck, 1'b0);
      end else begin
        push(StGameOver, 1'b0);
      end
    end
  endtask

  task automatic start_game();
    m_rn = 1; m_score = 0; m_hits = 0; m_dn = 1; m_shots = 3;
    push(StNewDuck, 1'b1);
    push(StNewDuck, 1'b0);
    // Start mid frame period so the new_round pulse is seen within NEW_DUCK.
    @(negedge bus.frame_clk);
    @(posedge Clk); #1;
    bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0;
    wait_state(StNewDuck, 5, "new_duck");
  endtask

  task automatic to_flying();
    push(StFlying, 1'b0);
    wait_state(StFlying, 60, "flying");
  endtask

  task automatic shoot(int dx, int dy, int ax, int ay, bit is_hit);
    bus.duck_x = 10'(dx);
    bus.duck_y = 10'(dy);
    bus.aim_x  = 10'(ax);
    bus.aim_y  = 10'(ay);
    if (m_shots > 0) begin
      m_shots--;
      if (is_hit) begin
        m_hits++;
        m_score += 500;
        push(StShot, 1'b0);
      end else begin
        push(StFlying, 1'b0);
      end
    end
    pull_trigger();
    if (is_hit && bus.state != StFlying) wait_state(StShot, 10, "shot");
  endtask

  task automatic finish_shot();
    decide();
    bus.duck_ded_done = 1'b1;
    @(posedge Clk); #1;
    bus.duck_ded_done = 1'b0;
  endtask

  // Count edges spent in FLEW (pre already elapsed) and check the frame budget.
  task automatic wait_flew_exit(int pre);
    int cyc;
    cyc = pre;
    while (bus.state == StFlew && cyc < 1500) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk("flew_duration_in_range", int'(cyc >= 1175 && cyc <= 1205), 1);
  endtask

  task automatic fly_away();
    push(StFlew, 1'b0);
    bus.flew_away = 1'b1;
    @(posedge Clk); #1;
    bus.flew_away = 1'b0;
    decide();
    // Trigger while in FLEW must be discarded.
    pull_trigger();
    wait_flew_exit(9);
  endtask

  // flew_away lands on the same edge the trigger edge is acted on.
  task automatic fly_and_trigger();
    bus.duck_x = 10'd100; bus.duck_y = 10'd100;
    bus.aim_x  = 10'd163; bus.aim_y  = 10'd163;
    push(StFlew, 1'b0);
    bus.trigger = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    bus.flew_away = 1'b1;
    @(posedge Clk); #1;
    bus.flew_away = 1'b0;
    decide();
    repeat (3) @(posedge Clk);
    #1 bus.trigger = 1'b0;
    wait_flew_exit(4);
  endtask

  int hit_tab [5][4] = '{'{100, 100, 163, 100}, '{100, 100, 100, 163}, '{100, 100, 130, 140},
                         '{50, 60, 113, 123}, '{100, 100, 120, 120}};
  int hit_tab2 [5][4] = '{'{100, 100, 100, 100}, '{1000, 1000, 1010, 1023},
                          '{100, 100, 163, 163}, '{0, 0, 0, 63}, '{200, 300, 263, 300}};

  initial begin
    bus.start = 1'b0; bus.trigger = 1'b0;
    bus.aim_x = '0; bus.aim_y = '0; bus.duck_x = 10'd100; bus.duck_y = 10'd100;
    bus.flew_away = 1'b0; bus.duck_ded_done = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("reset_state", int'(bus.state), 0);
    chk("reset_new_round", int'(bus.new_round), 0);
    chk("reset_shots", int'(bus.shots_left), 0);
    chk("reset_hits", int'(bus.hits), 0);
    chk("reset_duck_num", int'(bus.duck_num), 0);
    chk("reset_round", int'(bus.round_num), 0);
    chk("reset_score", int'(bus.score), 0);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    fork
      monitor();
    join_none

    // Round 1: hit, misses then empty gun, simultaneous fly/trigger, 5 hits, 2 fly-aways.
    start_game();
    to_flying();
    shoot(100, 100, 163, 163, 1'b1);
    finish_shot();
    to_flying();
    shoot(100, 100, 164, 100, 1'b0);
    shoot(100, 100, 99, 120, 1'b0);
    shoot(100, 100, 120, 164, 1'b0);
    shoot(100, 100, 100, 100, 1'b1);
    fly_away();
    to_flying();
    fly_and_trigger();
    for (int i = 0; i < 5; i++) begin
      to_flying();
      shoot(hit_tab[i][0], hit_tab[i][1], hit_tab[i][2], hit_tab[i][3], 1'b1);
      finish_shot();
    end
    for (int i = 0; i < 2; i++) begin
      to_flying();
      fly_away();
    end

    // Round 2: only five hits, so the game ends.
    for (int i = 0; i < 5; i++) begin
      to_flying();
      shoot(hit_tab2[i][0], hit_tab2[i][1], hit_tab2[i][2], hit_tab2[i][3], 1'b1);
      finish_shot();
    end
    for (int i = 0; i < 5; i++) begin
      to_flying();
      fly_away();
    end
    repeat (3) @(posedge Clk);
    #1;
    chk("game_over_state", int'(bus.state), int'(StGameOver));

    // Restart from GAME_OVER, then reset during SHOT with start held.
    start_game();
    to_flying();
    shoot(100, 100, 163, 163, 1'b1);
    m_shots = 0; m_hits = 0; m_dn = 0; m_rn = 0; m_score = 0;
    push(StIdle, 1'b0);
    Reset_n = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_mid_state", int'(bus.state), 0);
    chk("rst_mid_new_round", int'(bus.new_round), 0);
    chk("rst_mid_score", int'(bus.score), 0);
    chk("rst_mid_round", int'(bus.round_num), 0);
    bus.start = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("idle_after_reset", int'(bus.state), 0);
    chk("pending_expected", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
